// File: rtl/flow_seq_classifier.sv
// flow_seq_classifier: TCP sequence-tracking front end for the flow table.
// Bypasses ACK-only/UDP packets, delays tracked packets by LAT non-stalled
// cycles to meet the flow-table response, classifies them and emits the
// verdict, the OOO push and the flow-table write command.
// Optional feature macro: FT_SEQ_WRAP_EN (serial-number "ahead/behind").
module flow_seq_classifier #(
  parameter int SEQ_W   = 32,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 8,
  parameter int TAG_W   = 64,
  parameter int LOC_W   = 16,
  parameter int LAT     = 7,
  parameter int MAX_OOO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [SEQ_W-1:0] in_seq,
  input  logic [LEN_W-1:0] in_len,
  input  logic [7:0]       in_flags,
  input  logic             in_udp,
  output logic             fwd_valid,
  input  logic             fwd_ready,
  output logic [TAG_W-1:0] fwd_tag,
  output logic [1:0]       fwd_verdict,
  output logic             lk_valid,
  input  logic             lk_stall,
  input  logic             rsp_valid,
  input  logic             rsp_hit,
  input  logic [SEQ_W-1:0] rsp_seq,
  input  logic [CNT_W-1:0] rsp_slow_cnt,
  input  logic [LOC_W-1:0] rsp_loc,
  output logic             upd_valid,
  output logic [1:0]       upd_op,
  output logic [SEQ_W-1:0] upd_seq,
  output logic [CNT_W-1:0] upd_slow_cnt,
  output logic [LOC_W-1:0] upd_loc,
  input  logic             upd_stall,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_verdict,
  output logic             ooo_valid,
  output logic [TAG_W-1:0] ooo_tag,
  input  logic             out_almost_full,
  input  logic             ooo_almost_full
);
  localparam logic [1:0] V_FWD = 2'd0, V_CHK = 2'd1, V_DROP = 2'd2;
  localparam logic [1:0] OP_INS = 2'd1, OP_UPD = 2'd2, OP_DEL = 2'd3;

  logic byp, stall, dec;
  assign byp         = in_udp | (in_flags == 8'h10 && in_len == '0);
  assign stall       = lk_stall | upd_stall;
  assign in_ready    = byp ? fwd_ready : (!out_almost_full & !ooo_almost_full & !stall);
  assign fwd_valid   = in_valid & byp;
  assign fwd_tag     = in_tag;
  assign fwd_verdict = in_udp ? V_CHK : V_FWD;
  assign lk_valid    = in_valid & in_ready & !byp;

  // delay line; flags kept as {RST, SYN, FIN}
  logic [LAT-1:0]            vld_pipe;
  logic [LAT-1:0][TAG_W-1:0] tag_pipe;
  logic [LAT-1:0][SEQ_W-1:0] seq_pipe;
  logic [LAT-1:0][LEN_W-1:0] len_pipe;
  logic [LAT-1:0][2:0]       flg_pipe;

  // Delay line tracks the lookup engine: it only moves on non-stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      seq_pipe <= '0;
      len_pipe <= '0;
      flg_pipe <= '0;
    end else if (!stall) begin
      vld_pipe[0] <= lk_valid;
      tag_pipe[0] <= in_tag;
      seq_pipe[0] <= in_seq;
      len_pipe[0] <= in_len;
      flg_pipe[0] <= {in_flags[2], in_flags[1], in_flags[0]};
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
        seq_pipe[i] <= seq_pipe[i-1];
        len_pipe[i] <= len_pipe[i-1];
        flg_pipe[i] <= flg_pipe[i-1];
      end
    end
  end

  logic [TAG_W-1:0] t_tag;
  logic [SEQ_W-1:0] t_seq;
  logic [LEN_W-1:0] t_len;
  logic             fin_rst, syn, ahead;
  assign t_tag   = tag_pipe[LAT-1];
  assign t_seq   = seq_pipe[LAT-1];
  assign t_len   = len_pipe[LAT-1];
  assign fin_rst = flg_pipe[LAT-1][0] | flg_pipe[LAT-1][2];
  assign syn     = flg_pipe[LAT-1][1];
  assign dec     = !stall & rsp_valid & vld_pipe[LAT-1];

`ifdef FT_SEQ_WRAP_EN
  logic [SEQ_W-1:0] diff;
  assign diff  = t_seq - rsp_seq;
  assign ahead = (diff != '0) && !diff[SEQ_W-1];
`else
  assign ahead = t_seq > rsp_seq;
`endif

  logic             d_out, d_ooo, d_upd;
  logic [1:0]       d_verdict, d_op, len_rule;
  logic [SEQ_W-1:0] d_seq;
  logic [CNT_W-1:0] d_cnt;
  assign len_rule = (t_len != '0) ? V_CHK : V_FWD;

  // Classify the packet at the head of the delay line against the stored entry.
  always_comb begin
    d_out     = 1'b0;
    d_ooo     = 1'b0;
    d_upd     = 1'b0;
    d_verdict = V_FWD;
    d_op      = OP_UPD;
    d_seq     = rsp_seq;
    d_cnt     = rsp_slow_cnt + CNT_W'(1);
    if (rsp_hit) begin
      if (t_seq == rsp_seq) begin
        if (rsp_slow_cnt != '0) begin
          d_upd = 1'b1;
          d_ooo = 1'b1;
        end else begin
          d_upd     = 1'b1;
          d_op      = fin_rst ? OP_DEL : OP_UPD;
          d_seq     = rsp_seq + SEQ_W'(t_len);
          d_cnt     = '0;
          d_out     = 1'b1;
          d_verdict = len_rule;
        end
      end else if (ahead && rsp_slow_cnt < CNT_W'(MAX_OOO)) begin
        d_upd = 1'b1;
        d_ooo = 1'b1;
      end else begin
        // behind, or ahead with the OOO budget exhausted
        d_out     = 1'b1;
        d_verdict = V_DROP;
      end
    end else begin
      d_out     = 1'b1;
      d_verdict = len_rule;
      d_upd     = !fin_rst;
      d_op      = OP_INS;
      d_cnt     = '0;
      d_seq     = syn ? t_seq + SEQ_W'(1) : t_seq + SEQ_W'(t_len);
    end
  end

  // Result registers: pulses drop on stalls, the write command holds under upd_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_tag      <= '0;
      out_verdict  <= '0;
      ooo_valid    <= 1'b0;
      ooo_tag      <= '0;
      upd_valid    <= 1'b0;
      upd_op       <= '0;
      upd_seq      <= '0;
      upd_slow_cnt <= '0;
      upd_loc      <= '0;
    end else begin
      out_valid <= dec & d_out;
      ooo_valid <= dec & d_ooo;
      if (dec & d_out) begin
        out_tag     <= t_tag;
        out_verdict <= d_verdict;
      end
      if (dec & d_ooo) ooo_tag <= t_tag;
      if (!upd_stall) begin
        upd_valid <= dec & d_upd;
        if (dec & d_upd) begin
          upd_op       <= d_op;
          upd_seq      <= d_seq;
          upd_slow_cnt <= d_cnt;
          upd_loc      <= rsp_loc;
        end
      end
    end
  end
endmodule

// File: doc/flow_seq_classifier.md
# flow_seq_classifier

Parametrised TCP sequence-tracking front end for the flow table. It sits between the packet parser's metadata stream and the flow-table lookup/update channels. It bypasses ACK-only and UDP packets, aligns each tracked packet's tag with the flow-table response across a configurable lookup latency, and classifies the packet as in-order, out-of-order, overlap or new flow. It then emits a verdict, an OOO push and a flow-table write command.

## Interface
Parameters:
- SEQ_W, 32, sequence-number width
- LEN_W, 16, payload-length width
- CNT_W, 8, slow-path (OOO) counter width
- TAG_W, 64, opaque packet tag (metadata handle), carried unchanged
- LOC_W, 16, flow-entry location handle from lookup, echoed to update
- LAT, 7, lookup latency in non-stalled cycles, ≥1
- MAX_OOO, 255, slow_cnt ceiling, ≤ 2^CNT_W−1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in/out  1  input handshake
- in_tag  in  TAG_W  packet tag
- in_seq  in  SEQ_W  TCP sequence number
- in_len  in  LEN_W  payload bytes
- in_flags  in  8  TCP flags, with bit 0 FIN, 1 SYN, 2 RST, 4 ACK
- in_udp  in  1  packet is UDP
- fwd_valid / fwd_ready  out/in  1  bypass handshake
- fwd_tag, fwd_verdict  out  TAG_W, 2  bypass tag and verdict
- lk_valid  out  1  lookup request (the engine hashes the tuple itself)
- lk_stall  in  1  lookup engine stall
- rsp_valid, rsp_hit  in  1, 1  response valid and hit flag
- rsp_seq, rsp_slow_cnt, rsp_loc  in  SEQ_W, CNT_W, LOC_W  stored entry
- upd_valid  out  1  flow-table write command
- upd_op  out  2  1 INSERT, 2 UPDATE, 3 DELETE
- upd_seq, upd_slow_cnt, upd_loc  out  SEQ_W, CNT_W, LOC_W  written entry
- upd_stall  in  1  write channel busy
- out_valid, out_tag, out_verdict  out  1, TAG_W, 2  in-order path result
- ooo_valid, ooo_tag  out  1, TAG_W  slow-path push
- out_almost_full, ooo_almost_full  in  1  downstream FIFO levels

Verdict encoding: 0 FORWARD, 1 CHECK, 2 DROP.

## Operation
- Bypass condition: `byp = in_udp | (in_flags == 8'h10 && in_len == 0)`.
  - A bypassed packet drives `fwd_valid = in_valid` combinationally.
  - `fwd_verdict` is CHECK if UDP, otherwise FORWARD.
- `stall = lk_stall | upd_stall`.
- `in_ready = byp ? fwd_ready : !out_almost_full & !ooo_almost_full & !stall`.
- `lk_valid = in_valid & in_ready & !byp`. When lk_valid is high, the tag, seq, len and flags enter a LAT-deep delay line.
- The delay line advances only when !stall. The lookup engine holds the rsp_* signals stable while stall is high.
- The decision stage evaluates on non-stalled cycles with rsp_valid high. Let exp = rsp_seq and cnt = rsp_slow_cnt.
- Hit, seq == exp, cnt > 0: UPDATE with seq=exp and slow_cnt=cnt+1; pulse ooo_valid.
- Hit, seq == exp, cnt == 0: UPDATE with seq=exp+len (mod 2^SEQ_W); emit out with CHECK if len≠0, else FORWARD. If FIN or RST is set, issue DELETE instead.
- Hit, seq ahead of exp, cnt < MAX_OOO: UPDATE with seq=exp and slow_cnt=cnt+1; pulse ooo_valid.
- Hit, seq ahead of exp, cnt == MAX_OOO: no update; emit out with DROP (OOO overflow).
- Hit, seq behind exp: no update; emit out with DROP.
- Miss, FIN or RST set: no update; emit out with the len rule.
- Miss, otherwise: INSERT with slow_cnt=0 and upd_loc=rsp_loc. Stored seq is seq+1 if SYN, else seq+len. Emit out with the len rule.

## Timing
- Lookup request to response: exactly LAT non-stalled cycles.
- Response to out_valid / ooo_valid / upd_valid: 1 cycle, registered.
- out_valid and ooo_valid are single-cycle pulses and are cleared on any stall cycle.
- upd_* holds stable while upd_stall is high. It is consumed on the first cycle upd_stall is low, and a new decision may replace it on that same cycle.
- Reset: every valid output and every delay-line valid bit is 0, and all data registers are 0. In-flight packets are discarded.
- Fully pipelined: one packet per cycle when not stalled. Back-to-back packets on the same flow are not forwarded against each other, so the lookup engine owns that hazard.

## Configuration
- FT_SEQ_WRAP_EN defined:
  - "ahead" means (seq−exp) is nonzero with MSB 0, i.e. RFC 1982 serial arithmetic mod 2^SEQ_W.
  - "behind" means that MSB is 1.
- FT_SEQ_WRAP_EN undefined: plain unsigned comparison of seq against exp.

## Test plan
- UDP packet with fwd_ready=1 -> fwd_valid with verdict CHECK in the same cycle; lk_valid=0.
- Miss, SYN, seq=0x100 -> after LAT+1 cycles: INSERT with seq 0x101 and slow_cnt 0; out verdict FORWARD.
- Hit, exp=0x101, pkt seq=0x101, len=10, cnt 0 -> UPDATE seq 0x10B; out CHECK. The same case with FIN set -> DELETE.
- Hit, exp=0x200, pkt seq=0x300:
  - cnt=3 -> UPDATE with slow_cnt 4 and seq 0x200; ooo_valid pulses.
  - cnt=MAX_OOO -> out DROP; no upd.
- Wrap case: exp=0xFFFF_FFF0, seq=0x10.
  - With FT_SEQ_WRAP_EN -> treated as OOO.
  - Without it -> treated as behind; out DROP.
- Assert upd_stall for 5 cycles mid-stream -> upd_* held stable, in_ready=0, no packet lost or duplicated. Asserting rst mid-stream -> all valid outputs are 0 on the next cycle.
